// File: rtl/uart_pkg.sv
// Shared definitions for the bus-attached UART transmitter: register map,
// STATUS bit layout and serializer state encoding.
package uart_pkg;

    localparam int unsigned ADDR_W    = 2;
    localparam int unsigned DIV_W     = 16;
    localparam int unsigned BIT_CNT_W = 3;
    localparam int unsigned BYTE_W    = 8;

    // Word offsets within the block
    localparam logic [ADDR_W-1:0] REG_TXDATA  = 2'd0;
    localparam logic [ADDR_W-1:0] REG_STATUS  = 2'd1;
    localparam logic [ADDR_W-1:0] REG_DIVISOR = 2'd2;

    // STATUS bit indices
    localparam int unsigned ST_FULL    = 0;
    localparam int unsigned ST_EMPTY   = 1;
    localparam int unsigned ST_BUSY    = 2;
    localparam int unsigned ST_OVF     = 3;
    localparam int unsigned ST_LVL_LSB = 8;

    // STATUS read payload as seen on the bus
    typedef struct packed {
        logic [15:0] rsvd_hi;
        logic [7:0]  level;
        logic [3:0]  rsvd_lo;
        logic        ovf;
        logic        busy;
        logic        empty;
        logic        full;
    } status_t;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_START = 4'b0010,
        S_DATA  = 4'b0100,
        S_STOP  = 4'b1000
    } ser_state_e;

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with one extra pointer bit for full/empty disambiguation.
// Ports: clock/reset (sync, active-high); push/din write side (ignored when
// full); pop (ignored when empty); dout combinational from head; full, empty,
// level (0..2**LOG2) derived from the pointers.
module fifo_sync #(
    parameter int unsigned LOG2  = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LOG2:0]    level
);

    localparam int unsigned DEPTH = 1 << LOG2;
    localparam int unsigned PTR_W = LOG2 + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr_q[LOG2] != rd_ptr_q[LOG2]) &&
                     (wr_ptr_q[LOG2-1:0] == rd_ptr_q[LOG2-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign dout    = mem_q[rd_ptr_q[LOG2-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer update; pointers wrap naturally through the extra MSB
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Storage
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q[LOG2-1:0]] <= din;
    end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU word bus.
// Ports: clock, reset (sync, active-high); bus_sel/bus_addr/bus_data_w/
// bus_mask_w from the decoder and initiator (mask 0 = read); bus_data_r
// registered read data, zero when not read; tx serial line (idle high);
// irq_empty high while the FIFO is empty and the serializer is idle.
module bus_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_LOG2     = 4,
    parameter int unsigned DIVISOR_RESET = 867
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bus_sel,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [31:0]       bus_data_w,
    input  logic [3:0]        bus_mask_w,
    output logic [31:0]       bus_data_r,
    output logic              tx,
    output logic              irq_empty
);

    localparam int unsigned LVL_W = FIFO_LOG2 + 1;

    logic                 wr_en;
    logic                 rd_en;
    logic                 push;
    logic                 push_ok;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [BYTE_W-1:0]    fifo_dout;
    logic [LVL_W-1:0]     fifo_level;
    logic [LVL_W-1:0]     level_next;
    status_t              status;

    ser_state_e           state_q, state_d;
    logic [DIV_W-1:0]     baud_q, baud_d;
    logic [DIV_W-1:0]     divisor_q, divisor_d;
    logic [BIT_CNT_W-1:0] bit_q, bit_d;
    logic [BYTE_W-1:0]    shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 ovf_q, ovf_d;
    logic                 irq_q, irq_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 unused_bits;

    assign unused_bits = ^bus_data_w[31:16];

    fifo_sync #(
        .LOG2  (FIFO_LOG2),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_ok),
        .din   (bus_data_w[7:0]),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Bus decode, register writes and read mux (reads see pre-update state)
    always_comb begin
        wr_en   = bus_sel && (bus_mask_w != 4'b0000);
        rd_en   = bus_sel && (bus_mask_w == 4'b0000);
        push    = wr_en && (bus_addr == REG_TXDATA) && bus_mask_w[0];
        push_ok = push && !fifo_full;

        ovf_d = ovf_q;
        if (push && fifo_full) begin
            ovf_d = 1'b1;
        end else if (wr_en && (bus_addr == REG_STATUS) && bus_mask_w[0] &&
                     bus_data_w[ST_OVF]) begin
            ovf_d = 1'b0;
        end

        divisor_d = divisor_q;
        if (wr_en && (bus_addr == REG_DIVISOR)) begin
            if (bus_mask_w[0]) divisor_d[7:0]  = bus_data_w[7:0];
            if (bus_mask_w[1]) divisor_d[15:8] = bus_data_w[15:8];
        end

        status       = '0;
        status.full  = fifo_full;
        status.empty = fifo_empty;
        status.busy  = (state_q != S_IDLE);
        status.ovf   = ovf_q;
        status.level = 8'(fifo_level);

        rdata_d = '0;
        if (rd_en) begin
            case (bus_addr)
                REG_STATUS:  rdata_d = status;
                REG_DIVISOR: rdata_d = {16'h0000, divisor_q};
                default:     rdata_d = '0;
            endcase
        end
    end

    // Serializer next state; tx and irq are registered from the next state
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    baud_d  = divisor_q;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_q == '0) begin
                    baud_d  = divisor_q;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end
            S_DATA: begin
                if (baud_q == '0) begin
                    baud_d  = divisor_q;
                    shift_d = {1'b0, shift_q[BYTE_W-1:1]};
                    if (bit_q == BIT_CNT_W'(7)) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_CNT_W'(1);
                    end
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end
            S_STOP: begin
                if (baud_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase

        level_next = fifo_level + LVL_W'(push_ok) - LVL_W'(pop);
        irq_d      = (level_next == '0) && (state_d == S_IDLE);
    end

    // State and register file
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
            irq_q     <= 1'b1;
            divisor_q <= DIV_W'(DIVISOR_RESET);
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
            irq_q     <= irq_d;
            divisor_q <= divisor_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus_data_r = rdata_q;
    assign tx         = tx_q;
    assign irq_empty  = irq_q;

endmodule

// File: tb/tb_bus_uart_tx.sv
// Scoreboard bench for bus_uart_tx: read expectations and expected serial
// frames are queued by the stimulus and checked by independent monitors.
module tb_bus_uart_tx;
    import uart_pkg::*;

    logic        clock      = 1'b0;
    logic        reset      = 1'b1;
    logic        bus_sel    = 1'b0;
    logic [1:0]  bus_addr   = 2'd0;
    logic [31:0] bus_data_w = 32'd0;
    logic [3:0]  bus_mask_w = 4'd0;
    logic [31:0] bus_data_r;
    logic        tx;
    logic        irq_empty;

    bus_uart_tx #(
        .FIFO_LOG2     (4),
        .DIVISOR_RESET (867)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus_sel    (bus_sel),
        .bus_addr   (bus_addr),
        .bus_data_w (bus_data_w),
        .bus_mask_w (bus_mask_w),
        .bus_data_r (bus_data_r),
        .tx         (tx),
        .irq_empty  (irq_empty)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [9:0]       bits;
        logic [9:0][16:0] len;
    } frame_t;

    frame_t      exp_frames[$];
    logic [31:0] exp_rd[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    logic        chk_issue   = 1'b0;
    logic        rd_pend     = 1'b0;

    function automatic void cmp(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic void fail_evt(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event seen/absent contrary to expectation", name);
    endfunction

    function automatic frame_t mk_frame(input logic [7:0] b, input int unsigned len_a,
                                        input int unsigned len_b, input int unsigned sw);
        frame_t f;
        f.bits = {1'b1, b, 1'b0};
        for (int unsigned k = 0; k < 10; k++)
            f.len[k] = (k < sw) ? 17'(len_a) : 17'(len_b);
        return f;
    endfunction

    always @(posedge clock) begin
        cyc     <= cyc + 1;
        rd_pend <= chk_issue;
    end

    // Read monitor: one cycle after an observed read, bus_data_r must match
    always @(negedge clock) begin
        if (rd_pend) begin
            if (exp_rd.size() == 0) fail_evt("rd_no_expectation");
            else cmp("bus_data_r", bus_data_r, exp_rd.pop_front());
        end
    end

    // Serial monitor: bit values and per-bit durations of each frame
    initial begin : tx_monitor
        frame_t     cur;
        int         bi;
        int         cnt;
        logic       ok;
        logic       active;
        logic [9:0] rx;
        active = 1'b0;
        cur = '0; bi = 0; cnt = 0; ok = 1'b0; rx = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                active = 1'b0;
            end else if (!active) begin
                if (tx === 1'b0) begin
                    if (exp_frames.size() == 0) begin
                        fail_evt("tx_unexpected_frame");
                    end else begin
                        cur = exp_frames.pop_front();
                        active = 1'b1; bi = 0; cnt = 1; ok = 1'b1;
                        rx = '0; rx[0] = tx;
                    end
                end
            end else begin
                if (cnt == int'(cur.len[bi])) begin
                    bi++;
                    cnt = 0;
                end
                if (bi == 10) begin
                    if (tx !== 1'b1) ok = 1'b0;
                    cmp("tx_frame", 32'({ok, rx}), 32'({1'b1, cur.bits}));
                    active = 1'b0;
                end else begin
                    if (tx !== cur.bits[bi]) ok = 1'b0;
                    rx[bi] = tx;
                    cnt++;
                end
            end
        end
    end

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clock);
        bus_sel = 1'b1; bus_addr = a; bus_data_w = d; bus_mask_w = m;
        @(posedge clock);
        #1;
        bus_sel = 1'b0; bus_mask_w = 4'd0; bus_data_w = 32'd0;
    endtask

    task automatic bus_rd(input logic sel, input logic [1:0] a, input logic [31:0] exp);
        @(negedge clock);
        bus_sel = sel; bus_addr = a; bus_mask_w = 4'd0; chk_issue = 1'b1;
        exp_rd.push_back(exp);
        @(posedge clock);
        #1;
        bus_sel = 1'b0; chk_issue = 1'b0;
    endtask

    task automatic wait_irq(input int bound, output int n);
        n = 0;
        while (irq_empty !== 1'b1 && n < bound) begin
            @(posedge clock);
            #1;
            n++;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        int t0;
        n = 0; t0 = 0;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        cmp("reset_tx", 32'(tx), 32'd1);
        cmp("reset_irq", 32'(irq_empty), 32'd1);
        cmp("reset_rdata", bus_data_r, 32'd0);
        bus_rd(1'b1, REG_STATUS, 32'h0000_0002);
        bus_rd(1'b1, REG_DIVISOR, 32'd867);
        bus_rd(1'b1, REG_TXDATA, 32'd0);

        // Single frame 0xA5 at 4 clocks per bit
        bus_wr(REG_DIVISOR, 32'd3, 4'b0011);
        bus_rd(1'b1, REG_DIVISOR, 32'd3);
        exp_frames.push_back(mk_frame(8'hA5, 4, 4, 10));
        bus_wr(REG_TXDATA, 32'h0000_00A5, 4'b0001);
        cmp("irq_after_push", 32'(irq_empty), 32'd0);
        bus_rd(1'b1, REG_STATUS, 32'h0000_0100);
        bus_rd(1'b1, REG_STATUS, 32'h0000_0006);
        wait_irq(200, n);
        cmp("irq_rise_cycle", 32'(2 + n), 32'd41);

        // Divisor 3 -> 7 during data bit 2
        exp_frames.push_back(mk_frame(8'h3C, 4, 8, 4));
        bus_wr(REG_TXDATA, 32'h0000_003C, 4'b0001);
        repeat (14) @(posedge clock);
        bus_wr(REG_DIVISOR, 32'd7, 4'b0011);
        wait_irq(300, n);
        cmp("irq_after_div_change", 32'(n), 32'd50);

        // Byte lanes, read-only/reserved registers, deselected read
        bus_wr(REG_DIVISOR, 32'hABCD_12FF, 4'b0010);
        bus_rd(1'b1, REG_DIVISOR, 32'h0000_1207);
        bus_wr(REG_TXDATA, 32'h0000_5555, 4'b0010);
        bus_wr(REG_STATUS, 32'hFFFF_FFF7, 4'b1111);
        bus_rd(1'b1, REG_STATUS, 32'h0000_0002);
        cmp("irq_idle", 32'(irq_empty), 32'd1);
        bus_wr(2'd3, 32'hFFFF_FFFF, 4'b1111);
        bus_rd(1'b1, 2'd3, 32'd0);
        bus_rd(1'b0, REG_STATUS, 32'd0);

        // Fill to 16 plus the immediately popped byte, then overflow
        bus_wr(REG_DIVISOR, 32'd1000, 4'b0011);
        exp_frames.push_back(mk_frame(8'h10, 1001, 1001, 10));
        exp_frames.push_back(mk_frame(8'h11, 1001, 1001, 10));
        for (int i = 0; i < 17; i++) begin
            bus_wr(REG_TXDATA, 32'(8'h10 + i), 4'b0001);
            if (i == 0) t0 = cyc;
        end
        bus_rd(1'b1, REG_STATUS, 32'h0000_1005);
        bus_wr(REG_TXDATA, 32'h0000_00EE, 4'b0001);
        bus_rd(1'b1, REG_STATUS, 32'h0000_100D);
        bus_wr(REG_STATUS, 32'h0000_0008, 4'b0010);
        bus_rd(1'b1, REG_STATUS, 32'h0000_100D);
        bus_wr(REG_STATUS, 32'h0000_0008, 4'b0001);
        bus_rd(1'b1, REG_STATUS, 32'h0000_1005);

        // Push in the same cycle as the pop at level 16: dropped
        while (cyc != t0 + 10011) begin
            @(posedge clock);
            #1;
        end
        bus_wr(REG_TXDATA, 32'h0000_00EF, 4'b0001);
        bus_rd(1'b1, REG_STATUS, 32'h0000_0F0C);

        // Reset in the middle of the data bits
        do_reset();
        bus_rd(1'b1, REG_STATUS, 32'h0000_0002);
        bus_wr(REG_DIVISOR, 32'd3, 4'b0011);
        exp_frames.push_back(mk_frame(8'h00, 4, 4, 10));
        bus_wr(REG_TXDATA, 32'h0000_0000, 4'b0001);
        bus_wr(REG_TXDATA, 32'h0000_0000, 4'b0001);
        repeat (6) @(posedge clock);
        #1;
        cmp("tx_mid_data", 32'(tx), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        cmp("tx_after_reset", 32'(tx), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        bus_rd(1'b1, REG_STATUS, 32'h0000_0002);
        cmp("irq_after_reset", 32'(irq_empty), 32'd1);
        repeat (12) @(posedge clock);
        #1;
        cmp("tx_stays_idle", 32'(tx), 32'd1);

        repeat (3) @(negedge clock);
        cmp("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
        cmp("frame_queue_drained", 32'(exp_frames.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
